// File: rtl/fu_scheduler.sv
// fu_scheduler: tracks execution-unit occupancy and drives per-unit availability
// to the issue stage; sequences long ALU ops, memory requests and flush draining.
module fu_scheduler #(
  parameter int NUM_ALU    = 2,
  parameter int NUM_MEM    = 1,
  parameter int NUM_BRANCH = 1,
  parameter int LONG_LAT   = 8,
  parameter int LAT_BITS   = $clog2(LONG_LAT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wb_stall,
  input  logic [NUM_ALU-1:0]    alu_issue_valid,
  input  logic [NUM_ALU-1:0]    alu_issue_long,
  input  logic [NUM_MEM-1:0]    mem_issue_valid,
  input  logic [NUM_MEM-1:0]    mem_done,
  input  logic [NUM_BRANCH-1:0] branch_issue_valid,
  output logic [NUM_ALU-1:0]    alu_available,
  output logic [NUM_MEM-1:0]    mem_available,
  output logic [NUM_BRANCH-1:0] branch_available,
  output logic [NUM_ALU-1:0]    alu_long_done,
  output logic [NUM_MEM-1:0]    mem_squash,
  output logic                  issue_err
);

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_WAIT  = 2'd1,
    MEM_DRAIN = 2'd2
  } mem_state_e;

  localparam logic [LAT_BITS-1:0] CNT_LOAD = LAT_BITS'(LONG_LAT - 1);
  localparam logic [LAT_BITS-1:0] CNT_ONE  = LAT_BITS'(1);

  logic                gate;
  logic [LAT_BITS-1:0] cnt_q       [NUM_ALU];
  logic [LAT_BITS-1:0] cnt_d       [NUM_ALU];
  logic [NUM_ALU-1:0]  long_done_q;
  logic [NUM_ALU-1:0]  long_done_d;
  mem_state_e          mem_state_q [NUM_MEM];
  mem_state_e          mem_state_d [NUM_MEM];
  logic                issue_err_q;
  logic                issue_err_d;

  assign gate          = !flush && !wb_stall;
  assign alu_long_done = long_done_q;
  assign issue_err     = issue_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < NUM_ALU; a++) cnt_q[a] <= '0;
      for (int m = 0; m < NUM_MEM; m++) mem_state_q[m] <= MEM_IDLE;
      long_done_q <= '0;
      issue_err_q <= 1'b0;
    end else begin
      for (int a = 0; a < NUM_ALU; a++) cnt_q[a] <= cnt_d[a];
      for (int m = 0; m < NUM_MEM; m++) mem_state_q[m] <= mem_state_d[m];
      long_done_q <= long_done_d;
      issue_err_q <= issue_err_d;
    end
  end

  // ALU countdown: flush wins, a running count never reloads, load only when idle and gated
  always_comb begin
    for (int a = 0; a < NUM_ALU; a++) begin
      cnt_d[a]       = cnt_q[a];
      long_done_d[a] = 1'b0;
      if (flush) begin
        cnt_d[a] = '0;
      end else begin
        long_done_d[a] = (cnt_q[a] == CNT_ONE);
        if (cnt_q[a] != '0) begin
          cnt_d[a] = cnt_q[a] - CNT_ONE;
        end else if (gate && alu_issue_valid[a] && alu_issue_long[a]) begin
          cnt_d[a] = CNT_LOAD;
        end
      end
    end
  end

  always_comb begin
    for (int m = 0; m < NUM_MEM; m++) begin
      mem_state_d[m] = mem_state_q[m];
      case (mem_state_q[m])
        MEM_IDLE:  if (gate && mem_issue_valid[m]) mem_state_d[m] = MEM_WAIT;
        MEM_WAIT: begin
          if (mem_done[m])  mem_state_d[m] = MEM_IDLE;
          else if (flush)   mem_state_d[m] = MEM_DRAIN;
        end
        MEM_DRAIN: if (mem_done[m]) mem_state_d[m] = MEM_IDLE;
        default:   mem_state_d[m] = MEM_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int a = 0; a < NUM_ALU; a++) alu_available[a] = gate && (cnt_q[a] == '0);
    for (int b = 0; b < NUM_BRANCH; b++) branch_available[b] = gate;
    for (int m = 0; m < NUM_MEM; m++) begin
      mem_available[m] = gate && (mem_state_q[m] == MEM_IDLE);
      mem_squash[m]    = mem_done[m] && ((mem_state_q[m] == MEM_DRAIN) ||
                                         ((mem_state_q[m] == MEM_WAIT) && flush));
    end
  end

  // Sticky error: issues during flush are dropped silently, stray completions are not
  always_comb begin
    issue_err_d = issue_err_q;
    if (!flush) begin
      for (int a = 0; a < NUM_ALU; a++)
        if (alu_issue_valid[a] && !alu_available[a]) issue_err_d = 1'b1;
      for (int m = 0; m < NUM_MEM; m++)
        if (mem_issue_valid[m] && !mem_available[m]) issue_err_d = 1'b1;
      for (int b = 0; b < NUM_BRANCH; b++)
        if (branch_issue_valid[b] && !branch_available[b]) issue_err_d = 1'b1;
    end
    for (int m = 0; m < NUM_MEM; m++)
      if (mem_done[m] && (mem_state_q[m] == MEM_IDLE)) issue_err_d = 1'b1;
  end

endmodule

// File: tb/tb_fu_scheduler.sv
// Bench for fu_scheduler: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a cycle-number based model.
module tb_fu_scheduler;
  localparam int NUM_ALU    = 2;
  localparam int NUM_MEM    = 1;
  localparam int NUM_BRANCH = 1;
  localparam int LONG_LAT   = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush, wb_stall;
  logic [NUM_ALU-1:0]    alu_issue_valid, alu_issue_long;
  logic [NUM_MEM-1:0]    mem_issue_valid, mem_done;
  logic [NUM_BRANCH-1:0] branch_issue_valid;
  logic [NUM_ALU-1:0]    alu_available, alu_long_done;
  logic [NUM_MEM-1:0]    mem_available, mem_squash;
  logic [NUM_BRANCH-1:0] branch_available;
  logic                  issue_err;

  fu_scheduler #(
    .NUM_ALU(NUM_ALU), .NUM_MEM(NUM_MEM), .NUM_BRANCH(NUM_BRANCH), .LONG_LAT(LONG_LAT)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .wb_stall(wb_stall),
    .alu_issue_valid(alu_issue_valid), .alu_issue_long(alu_issue_long),
    .mem_issue_valid(mem_issue_valid), .mem_done(mem_done),
    .branch_issue_valid(branch_issue_valid),
    .alu_available(alu_available), .mem_available(mem_available),
    .branch_available(branch_available), .alu_long_done(alu_long_done),
    .mem_squash(mem_squash), .issue_err(issue_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: cycle in which each ALU accepted its pending long op (-1 none),
  // whether each mem unit has a request outstanding and whether it was flushed.
  int alu_t   [NUM_ALU];
  bit mem_out [NUM_MEM];
  bit mem_sq  [NUM_MEM];
  bit m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0; wb_stall = 1'b0;
    alu_issue_valid = '0; alu_issue_long = '0;
    mem_issue_valid = '0; mem_done = '0; branch_issue_valid = '0;
  endtask

  task automatic model_reset();
    for (int a = 0; a < NUM_ALU; a++) alu_t[a] = -1;
    for (int m = 0; m < NUM_MEM; m++) begin mem_out[m] = 1'b0; mem_sq[m] = 1'b0; end
    m_err = 1'b0;
  endtask

  function automatic bit alu_free(input int a);
    return !(alu_t[a] >= 0 && cyc < alu_t[a] + LONG_LAT);
  endfunction

  // Compare current-cycle outputs with the model, then advance the model past the edge.
  task automatic step();
    logic [NUM_ALU-1:0]    e_av, e_dn;
    logic [NUM_MEM-1:0]    e_mav, e_sq;
    logic [NUM_BRANCH-1:0] e_bav;
    bit gate, err_now;
    gate = !flush && !wb_stall;
    for (int a = 0; a < NUM_ALU; a++) begin
      e_av[a] = gate && alu_free(a);
      e_dn[a] = (alu_t[a] >= 0) && (cyc == alu_t[a] + LONG_LAT);
    end
    for (int m = 0; m < NUM_MEM; m++) begin
      e_mav[m] = gate && !mem_out[m];
      e_sq[m]  = mem_out[m] && mem_done[m] && (mem_sq[m] || flush);
    end
    for (int b = 0; b < NUM_BRANCH; b++) e_bav[b] = gate;
    chk($sformatf("alu_available@%0d", cyc), alu_available, e_av);
    chk($sformatf("alu_long_done@%0d", cyc), alu_long_done, e_dn);
    chk($sformatf("mem_available@%0d", cyc), mem_available, e_mav);
    chk($sformatf("mem_squash@%0d", cyc), mem_squash, e_sq);
    chk($sformatf("branch_available@%0d", cyc), branch_available, e_bav);
    chk($sformatf("issue_err@%0d", cyc), issue_err, m_err);

    err_now = 1'b0;
    for (int a = 0; a < NUM_ALU; a++) begin
      if (!flush && alu_issue_valid[a] && !e_av[a]) err_now = 1'b1;
      if (alu_t[a] >= 0 && cyc >= alu_t[a] + LONG_LAT) alu_t[a] = -1;
      if (flush) alu_t[a] = -1;
      else if (alu_issue_valid[a] && alu_issue_long[a] && e_av[a]) alu_t[a] = cyc;
    end
    for (int m = 0; m < NUM_MEM; m++) begin
      if (!flush && mem_issue_valid[m] && !e_mav[m]) err_now = 1'b1;
      if (mem_done[m] && !mem_out[m]) err_now = 1'b1;
      if (mem_out[m]) begin
        if (mem_done[m]) begin mem_out[m] = 1'b0; mem_sq[m] = 1'b0; end
        else if (flush)  mem_sq[m] = 1'b1;
      end else if (mem_issue_valid[m] && e_mav[m]) begin
        mem_out[m] = 1'b1; mem_sq[m] = 1'b0;
      end
    end
    for (int b = 0; b < NUM_BRANCH; b++)
      if (!flush && branch_issue_valid[b] && !e_bav[b]) err_now = 1'b1;
    m_err = m_err | err_now;

    @(negedge clk);
    cyc++;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic rand_inputs(input bit legal);
    bit gate;
    idle_inputs();
    flush    = ($urandom_range(0, 15) == 0);
    wb_stall = ($urandom_range(0, 7) == 0);
    gate = !flush && !wb_stall;
    for (int a = 0; a < NUM_ALU; a++) begin
      alu_issue_valid[a] = ($urandom_range(0, 2) == 0);
      if (legal && !(gate && alu_free(a))) alu_issue_valid[a] = 1'b0;
      alu_issue_long[a] = alu_issue_valid[a] && ($urandom_range(0, 1) == 1);
    end
    for (int m = 0; m < NUM_MEM; m++) begin
      mem_issue_valid[m] = ($urandom_range(0, 2) == 0);
      if (legal && !(gate && !mem_out[m])) mem_issue_valid[m] = 1'b0;
      mem_done[m] = ($urandom_range(0, 3) == 0);
      if (legal && !mem_out[m]) mem_done[m] = 1'b0;
    end
    for (int b = 0; b < NUM_BRANCH; b++) begin
      branch_issue_valid[b] = ($urandom_range(0, 2) == 0);
      if (legal && !gate) branch_issue_valid[b] = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < LONG_LAT + 4; i++) begin
      idle_inputs();
      for (int m = 0; m < NUM_MEM; m++) mem_done[m] = mem_out[m];
      settle();
      step();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_alu_available"}, alu_available, 2'b11);
    chk({tag, "_mem_available"}, mem_available, 1'b1);
    chk({tag, "_branch_available"}, branch_available, 1'b1);
    chk({tag, "_issue_err"}, issue_err, 1'b0);
    chk({tag, "_alu_long_done"}, alu_long_done, 2'b00);
    chk({tag, "_mem_squash"}, mem_squash, 1'b0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    settle();
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    settle();
    check_reset_outputs("post_reset");
    step();

    // Long op on ALU0 at k=10.
    for (int k = 0; k <= 20; k++) begin
      idle_inputs();
      if (k == 10) begin alu_issue_valid = 2'b01; alu_issue_long = 2'b01; end
      settle();
      if (k >= 11 && k <= 17) chk($sformatf("t2_avail0_busy_k%0d", k), alu_available[0], 1'b0);
      if (k == 18) chk("t2_avail0_free_k18", alu_available[0], 1'b1);
      if (k >= 10) chk($sformatf("t2_done0_k%0d", k), alu_long_done[0], (k == 18));
      chk($sformatf("t2_avail1_k%0d", k), alu_available[1], 1'b1);
      step();
    end

    // Mem request completes normally.
    for (int k = 0; k <= 12; k++) begin
      idle_inputs();
      if (k == 5) mem_issue_valid = 1'b1;
      if (k == 9) mem_done = 1'b1;
      settle();
      chk($sformatf("t3_mem_avail_k%0d", k), mem_available, !(k >= 6 && k <= 9));
      chk($sformatf("t3_squash_k%0d", k), mem_squash, 1'b0);
      step();
    end

    // Mem request flushed, then drained.
    for (int k = 0; k <= 15; k++) begin
      idle_inputs();
      if (k == 5)  mem_issue_valid = 1'b1;
      if (k == 7)  flush = 1'b1;
      if (k == 12) mem_done = 1'b1;
      settle();
      chk($sformatf("t4_mem_avail_k%0d", k), mem_available, (k <= 5 || k >= 13));
      chk($sformatf("t4_squash_k%0d", k), mem_squash, (k == 12));
      step();
    end

    // Long op on ALU1 squashed by flush.
    for (int k = 0; k <= 12; k++) begin
      idle_inputs();
      if (k == 0) begin alu_issue_valid = 2'b10; alu_issue_long = 2'b10; end
      if (k == 3) flush = 1'b1;
      settle();
      if (k == 1 || k == 2) chk($sformatf("t5_avail1_busy_k%0d", k), alu_available[1], 1'b0);
      if (k == 4) chk("t5_avail1_free_k4", alu_available[1], 1'b1);
      chk($sformatf("t5_done1_k%0d", k), alu_long_done[1], 1'b0);
      step();
    end

    for (int i = 0; i < 400; i++) begin
      rand_inputs(1'b1);
      settle();
      step();
    end
    drain();

    // Issue to a busy ALU, then a writeback stall.
    for (int k = 0; k <= 10; k++) begin
      idle_inputs();
      if (k == 0) begin alu_issue_valid = 2'b01; alu_issue_long = 2'b01; end
      if (k == 2) alu_issue_valid = 2'b01;
      if (k == 4) wb_stall = 1'b1;
      settle();
      chk($sformatf("t6_err_k%0d", k), issue_err, (k >= 3));
      if (k >= 1 && k <= 7) chk($sformatf("t6_avail0_busy_k%0d", k), alu_available[0], 1'b0);
      if (k == 8) begin
        chk("t6_avail0_free_k8", alu_available[0], 1'b1);
        chk("t6_done0_k8", alu_long_done[0], 1'b1);
      end
      if (k == 4) begin
        chk("t6_stall_alu", alu_available, 2'b00);
        chk("t6_stall_mem", mem_available, 1'b0);
        chk("t6_stall_branch", branch_available, 1'b0);
      end
      step();
    end

    // Reset in the middle of a long op and an outstanding request.
    idle_inputs();
    alu_issue_valid = 2'b10; alu_issue_long = 2'b10; mem_issue_valid = 1'b1;
    settle();
    step();
    idle_inputs();
    settle();
    step();
    rst = 1'b0;
    settle();
    check_reset_outputs("midop_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < LONG_LAT + 4; i++) begin
      idle_inputs();
      settle();
      step();
    end

    for (int i = 0; i < 300; i++) begin
      rand_inputs(1'b0);
      settle();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
